dual_port_mem_responder: RTL

DUAL_PORT_MEM_RESPONDER -- requirements
Module: dual_port_mem_responder

---
 rtl/dual_port_mem_responder_if.sv | 32 +++
 rtl/dual_port_mem_responder.sv | 121 ++++++++++++
 2 files changed

// File: rtl/dual_port_mem_responder_if.sv
// Dual-port memory bus: two independent word-addressed read/write ports plus ready.
interface dual_port_mem_responder_if;
  localparam int unsigned ADDR_IN_W = 17;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BE_W      = DATA_W / 8;

  logic [ADDR_IN_W-1:0] address_a;
  logic [BE_W-1:0]      byteena_a;
  logic [DATA_W-1:0]    data_a;
  logic                 wren_a;
  logic [DATA_W-1:0]    q_a;

  logic [ADDR_IN_W-1:0] address_b;
  logic [BE_W-1:0]      byteena_b;
  logic [DATA_W-1:0]    data_b;
  logic                 wren_b;
  logic [DATA_W-1:0]    q_b;

  logic                 ready;

  modport master (
    output address_a, byteena_a, data_a, wren_a,
    output address_b, byteena_b, data_b, wren_b,
    input  q_a, q_b, ready
  );

  modport slave (
    input  address_a, byteena_a, data_a, wren_a,
    input  address_b, byteena_b, data_b, wren_b,
    output q_a, q_b, ready
  );
endinterface

// File: rtl/dual_port_mem_responder.sv
// Dual-port 32-bit word memory with byte enables, 1-cycle registered reads,
// port-A-wins write merge, and an optional zero-fill sweep after reset.
module dual_port_mem_responder #(
  parameter int unsigned ADDR_W         = 12,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic                      clk,
  input logic                      reset,
  dual_port_mem_responder_if.slave bus
);

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BE_W      = DATA_W / 8;
  localparam int unsigned ADDR_IN_W = 17;
  localparam int unsigned DEPTH     = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic [ADDR_W-1:0]   w_clr_cnt_nxt;
  logic                w_clr_we;
  logic                r_ready;
  logic [DATA_W-1:0]   r_q_a;
  logic [DATA_W-1:0]   r_q_b;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_inrange_a;
  logic                w_inrange_b;
  logic [ADDR_W-1:0]   w_idx_a;
  logic [ADDR_W-1:0]   w_idx_b;
  logic                w_we_a;
  logic                w_we_b;

  // Address decode: any set bit above the implemented range makes the access a no-op
  assign w_inrange_a = ((bus.address_a >> ADDR_W) == ADDR_IN_W'(0));
  assign w_inrange_b = ((bus.address_b >> ADDR_W) == ADDR_IN_W'(0));
  assign w_idx_a     = bus.address_a[ADDR_W-1:0];
  assign w_idx_b     = bus.address_b[ADDR_W-1:0];
  // r_ready is low while reset is held and throughout the sweep, so it also blocks writes then
  assign w_we_a      = r_ready && bus.wren_a && w_inrange_a;
  assign w_we_b      = r_ready && bus.wren_b && w_inrange_b;

  // FSM next state: sweep one word per cycle, leave CLEAR on the edge that writes the last word
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_clr_we      = 1'b0;
    case (r_state)
      CLEAR: begin
        w_clr_we = 1'b1;
        if (r_clr_cnt == {ADDR_W{1'b1}}) begin
          w_state_nxt = READY;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
        end
      end
      READY: begin
        w_state_nxt = READY;
      end
      default: begin
        w_state_nxt = READY;
      end
    endcase
  end

  // FSM state, sweep counter and ready flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if (CLEAR_ON_RESET) begin
        r_state <= CLEAR;
      end else begin
        r_state <= READY;
      end
      r_clr_cnt <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_ready   <= (w_state_nxt == READY);
    end
  end

  // Registered read ports; old contents are returned on read-during-write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q_a <= '0;
      r_q_b <= '0;
    end else if (r_state == READY) begin
      r_q_a <= w_inrange_a ? r_mem[w_idx_a] : DATA_W'(0);
      r_q_b <= w_inrange_b ? r_mem[w_idx_b] : DATA_W'(0);
    end else begin
      r_q_a <= '0;
      r_q_b <= '0;
    end
  end

  // Array writes: sweep clear, then port B, then port A so A wins per byte on collisions
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt] <= '0;
    end
    for (int i = 0; i < int'(BE_W); i++) begin
      if (w_we_b && bus.byteena_b[i]) begin
        r_mem[w_idx_b][8*i +: 8] <= bus.data_b[8*i +: 8];
      end
      if (w_we_a && bus.byteena_a[i]) begin
        r_mem[w_idx_a][8*i +: 8] <= bus.data_a[8*i +: 8];
      end
    end
  end

  assign bus.q_a   = r_q_a;
  assign bus.q_b   = r_q_b;
  assign bus.ready = r_ready;

endmodule
